eth_pcspma_link_mon: RTL and testbench
======================================

ETH_PCSPMA_LINK_MON -- requirements
Module: eth_pcspma_link_mon

Interface
REQ-001 SHALL have parameter CH_COUNT, default 1: number of PCS/PMA channels monitored (1..8).
REQ-002 SHALL have parameter HOLD_CYCLES, default 1024: consecutive good-status cycles required before link is declared up (>=1).
REQ-003 SHALL have parameter LINK_TIMEOUT, default 125000000: cycles without link before autonegotiation restart (>=8).
REQ-004 SHALL have a single clock, clk; reset rst is synchronous and active-high.
REQ-005 Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- status_vector  input  CH_COUNT*16  per-channel PCS/PMA status; channel n at [16n+15:16n]; synchronous to clk
- an_restart  output  CH_COUNT  per-channel autonegotiation restart
- speed_is_10_100  output  CH_COUNT  per-channel speed control to PCS/PMA
- speed_is_100  output  CH_COUNT  per-channel speed control to PCS/PMA
- link_up  output  CH_COUNT  qualified link state
- link_change  output  CH_COUNT  one-cycle pulse on any link_up transition
- flap_count  output  CH_COUNT*8  per-channel link-down event count; channel n at [8n+7:8n]
- led_sel_ch  input  3  channel selected for LED debug
- led_sel_hi  input  1  0 = status bits [7:0], 1 = bits [15:8]
- led_out  output  8  registered debug view of selected status byte

Function
REQ-006 "Good" for channel n SHALL be status bit 0 (link_status) AND bit 1 (link_synchronization).
REQ-007 Per-channel FSM SHALL have states DOWN, QUAL, UP, RESTART.
REQ-008 DOWN: good -> QUAL with hold counter = 1; else stay.
REQ-009 QUAL: not good -> DOWN; good with hold counter = HOLD_CYCLES -> UP; else hold counter +1.
REQ-010 link_up SHALL be 1 only in UP; with good continuously high from edge k, link_up rises at edge k+HOLD_CYCLES.
REQ-011 UP: not good -> DOWN in one cycle; flap_count +1, saturating at 255.
REQ-012 link_change SHALL pulse high for exactly the one cycle after each entry into or exit from UP.
REQ-013 Timeout counter SHALL increment each cycle in DOWN or QUAL, clear on entering UP; counter reaching LINK_TIMEOUT-1 in DOWN/QUAL -> RESTART.
REQ-014 RESTART: an_restart[n] high for exactly 4 cycles, status ignored, then DOWN with timeout counter = 0.
REQ-015 Speed field [11:10] SHALL be latched while in UP: 2'b10 -> speed_is_10_100=0, speed_is_100=0; 2'b01 -> 1,1; 2'b00 -> 1,0; 2'b11 -> hold previous; held outside UP.
REQ-016 led_out SHALL equal the selected byte of channel led_sel_ch with 1-cycle latency; led_sel_ch >= CH_COUNT -> 8'h00.
REQ-017 Channels SHALL be fully independent; simultaneous events on several channels SHALL be handled in the same cycle.

Reset
REQ-018 On rst: all FSMs DOWN; hold/timeout counters 0; link_up, link_change, an_restart, flap_count, led_out 0; speed_is_10_100=0, speed_is_100=0 (1000 Mb/s).
REQ-019 rst asserted mid-RESTART SHALL drop an_restart the next cycle; no partial pulse resumes after reset.

Configuration
REQ-020 Macro LINK_MON_AUTO_RESTART_EN: defined -> REQ-013/REQ-014 active; undefined -> RESTART unreachable, timeout counter absent, an_restart tied 0, DOWN waits indefinitely.

Structure
REQ-021 Package eth_pcspma_link_mon_pkg SHALL hold the FSM state enum, status bit index constants (LINK, SYNC, SPEED_LSB/MSB) and speed codes.
REQ-022 Per-channel logic SHALL be sub-module eth_pcspma_link_mon_ch, instantiated CH_COUNT times; LED mux in the top.

Verification (HOLD_CYCLES=16, LINK_TIMEOUT=64, CH_COUNT=2)
REQ-023 Status ch0 = 16'h0803 held from edge 10 -> link_up[0] rises at edge 26, link_change[0] 1-cycle pulse, speed outputs 0/0.
REQ-024 Good for 10 cycles then bit1 low -> link_up stays 0, QUAL restarts on next good; drop while UP -> flap_count[0]=1, link_change pulse.
REQ-025 Status 0 for 64 cycles with macro defined -> an_restart[0] high exactly 4 cycles, repeats every 68 cycles; without macro never asserts.
REQ-026 Ch1 speed 2'b01 while UP -> speed_is_10_100[1]=1, speed_is_100[1]=1; then 2'b11 -> unchanged.
REQ-027 led_sel_ch=1, led_sel_hi=1, ch1 status 16'hA5C3 -> led_out=8'hA5 next cycle; led_sel_ch=5 -> 8'h00.
REQ-028 rst pulsed during RESTART and 300 flaps -> all outputs per REQ-018 next cycle; flap_count saturates at 255 before reset.

Source files
------------

// File: rtl/eth_pcspma_link_mon_pkg.sv
// Shared types and constants for the PCS/PMA link monitor: FSM states, status bit positions, speed codes.
package eth_pcspma_link_mon_pkg;

    typedef enum logic [1:0] {
        ST_DOWN    = 2'd0,
        ST_QUAL    = 2'd1,
        ST_UP      = 2'd2,
        ST_RESTART = 2'd3
    } link_state_e;

    localparam int unsigned STAT_LINK      = 0;
    localparam int unsigned STAT_SYNC      = 1;
    localparam int unsigned STAT_SPEED_LSB = 10;
    localparam int unsigned STAT_SPEED_MSB = 11;

    localparam logic [1:0] SPEED_1000 = 2'b10;
    localparam logic [1:0] SPEED_100  = 2'b01;
    localparam logic [1:0] SPEED_10   = 2'b00;
    localparam logic [1:0] SPEED_KEEP = 2'b11;

    function automatic logic status_good(input logic [15:0] status);
        return status[STAT_LINK] & status[STAT_SYNC];
    endfunction

endpackage

// File: rtl/eth_pcspma_link_mon_ch.sv
// One channel: qualifies link (DOWN/QUAL/UP), counts flaps, latches speed; outputs registered, no backpressure.
// Autonegotiation restart on timeout exists only when LINK_MON_AUTO_RESTART_EN is defined.
module eth_pcspma_link_mon_ch
    import eth_pcspma_link_mon_pkg::*;
#(
    parameter int HOLD_CYCLES  = 1024,
    parameter int LINK_TIMEOUT = 125000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] status_i,
    output logic        an_restart_o,
    output logic        speed_is_10_100_o,
    output logic        speed_is_100_o,
    output logic        link_up_o,
    output logic        link_change_o,
    output logic [7:0]  flap_count_o
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    if (HOLD_CYCLES < 1 || LINK_TIMEOUT < 8) begin : g_param_check
        $error("eth_pcspma_link_mon_ch: HOLD_CYCLES must be >=1 and LINK_TIMEOUT >=8");
    end

    link_state_e       state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [7:0]        flap_q, flap_d;
    logic              chg_q;
    logic              spd_10_100_q, spd_10_100_d;
    logic              spd_100_q, spd_100_d;
    logic              good;
    logic              unused_status;

    assign good          = status_good(status_i);
    assign unused_status = ^{status_i[15:12], status_i[9:2]};

`ifdef LINK_MON_AUTO_RESTART_EN
    localparam int TMO_W = $clog2(LINK_TIMEOUT);
    localparam int RESTART_CYCLES = 4;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LINK_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] RST_LAST = TMO_W'(RESTART_CYCLES - 1);

    // The timeout counter doubles as the restart pulse-width counter.
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        flap_d       = flap_q;
        spd_10_100_d = spd_10_100_q;
        spd_100_d    = spd_100_q;
        case (state_q)
            ST_DOWN: begin
                if (good) begin
                    state_d = ST_QUAL;
                    hold_d  = HOLD_W'(1);
                end
            end
            ST_QUAL: begin
                if (!good) begin
                    state_d = ST_DOWN;
                end else if (hold_q == HOLD_W'(HOLD_CYCLES)) begin
                    state_d = ST_UP;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_UP: begin
                if (!good) begin
                    state_d = ST_DOWN;
                    if (flap_q != 8'hFF) begin
                        flap_d = flap_q + 8'd1;
                    end
                end else begin
                    case (status_i[STAT_SPEED_MSB:STAT_SPEED_LSB])
                        SPEED_1000: begin spd_10_100_d = 1'b0; spd_100_d = 1'b0; end
                        SPEED_100:  begin spd_10_100_d = 1'b1; spd_100_d = 1'b1; end
                        SPEED_10:   begin spd_10_100_d = 1'b1; spd_100_d = 1'b0; end
                        SPEED_KEEP: begin end
                    endcase
                end
            end
            default: state_d = ST_DOWN;
        endcase
`ifdef LINK_MON_AUTO_RESTART_EN
        tmo_d = tmo_q;
        case (state_q)
            ST_DOWN, ST_QUAL: begin
                // A completed qualification wins over a coincident timeout.
                if (state_d == ST_UP) begin
                    tmo_d = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_RESTART;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_RESTART: begin
                if (tmo_q == RST_LAST) begin
                    state_d = ST_DOWN;
                    tmo_d   = '0;
                end else begin
                    state_d = ST_RESTART;
                    tmo_d   = tmo_q + TMO_W'(1);
                end
            end
            default: tmo_d = '0;
        endcase
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_DOWN;
            hold_q       <= '0;
            flap_q       <= '0;
            chg_q        <= 1'b0;
            spd_10_100_q <= 1'b0;
            spd_100_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            flap_q       <= flap_d;
            chg_q        <= (state_d == ST_UP) != (state_q == ST_UP);
            spd_10_100_q <= spd_10_100_d;
            spd_100_q    <= spd_100_d;
        end
    end

`ifdef LINK_MON_AUTO_RESTART_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign an_restart_o = (state_q == ST_RESTART);
`else
    assign an_restart_o = 1'b0;
`endif

    assign link_up_o         = (state_q == ST_UP);
    assign link_change_o     = chg_q;
    assign flap_count_o      = flap_q;
    assign speed_is_10_100_o = spd_10_100_q;
    assign speed_is_100_o    = spd_100_q;

endmodule

// File: rtl/eth_pcspma_link_mon.sv
// Multi-channel PCS/PMA link monitor with registered LED debug byte (1-cycle latency); no backpressure.
// Optional timeout-driven autonegotiation restart: LINK_MON_AUTO_RESTART_EN.
module eth_pcspma_link_mon
    import eth_pcspma_link_mon_pkg::*;
#(
    parameter int CH_COUNT     = 1,
    parameter int HOLD_CYCLES  = 1024,
    parameter int LINK_TIMEOUT = 125000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH_COUNT*16-1:0] status_vector,
    output logic [CH_COUNT-1:0]   an_restart,
    output logic [CH_COUNT-1:0]   speed_is_10_100,
    output logic [CH_COUNT-1:0]   speed_is_100,
    output logic [CH_COUNT-1:0]   link_up,
    output logic [CH_COUNT-1:0]   link_change,
    output logic [CH_COUNT*8-1:0] flap_count,
    input  logic [2:0]            led_sel_ch,
    input  logic                  led_sel_hi,
    output logic [7:0]            led_out
);

    if (CH_COUNT < 1 || CH_COUNT > 8) begin : g_param_check
        $error("eth_pcspma_link_mon: CH_COUNT must be 1..8");
    end

    logic [7:0] led_q, led_d;

    for (genvar n = 0; n < CH_COUNT; n++) begin : g_ch
        eth_pcspma_link_mon_ch #(
            .HOLD_CYCLES  (HOLD_CYCLES),
            .LINK_TIMEOUT (LINK_TIMEOUT)
        ) u_ch (
            .clk_i             (clk),
            .rst_i             (rst),
            .status_i          (status_vector[16*n +: 16]),
            .an_restart_o      (an_restart[n]),
            .speed_is_10_100_o (speed_is_10_100[n]),
            .speed_is_100_o    (speed_is_100[n]),
            .link_up_o         (link_up[n]),
            .link_change_o     (link_change[n]),
            .flap_count_o      (flap_count[8*n +: 8])
        );
    end

    // Unpopulated channel selections fall through to zero.
    always_comb begin
        led_d = 8'h00;
        for (int n = 0; n < CH_COUNT; n++) begin
            if (led_sel_ch == 3'(n)) begin
                led_d = led_sel_hi ? status_vector[16*n+8 +: 8] : status_vector[16*n +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= 8'h00;
        end else begin
            led_q <= led_d;
        end
    end

    assign led_out = led_q;

endmodule

// File: tb/tb_eth_pcspma_link_mon.sv
// Directed bench for eth_pcspma_link_mon (CH_COUNT=2, HOLD_CYCLES=16, LINK_TIMEOUT=64).
module tb_eth_pcspma_link_mon;

    localparam int CH   = 2;
    localparam int HOLD = 16;
    localparam int TMO  = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] status_vector;
    logic [1:0]  an_restart, speed_is_10_100, speed_is_100, link_up, link_change;
    logic [15:0] flap_count;
    logic [2:0]  led_sel_ch;
    logic        led_sel_hi;
    logic [7:0]  led_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    eth_pcspma_link_mon #(
        .CH_COUNT     (CH),
        .HOLD_CYCLES  (HOLD),
        .LINK_TIMEOUT (TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .status_vector   (status_vector),
        .an_restart      (an_restart),
        .speed_is_10_100 (speed_is_10_100),
        .speed_is_100    (speed_is_100),
        .link_up         (link_up),
        .link_change     (link_change),
        .flap_count      (flap_count),
        .led_sel_ch      (led_sel_ch),
        .led_sel_hi      (led_sel_hi),
        .led_out         (led_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_link_up"}, 32'(link_up), 32'h0);
        check({tag, "_link_change"}, 32'(link_change), 32'h0);
        check({tag, "_an_restart"}, 32'(an_restart), 32'h0);
        check({tag, "_flap"}, 32'(flap_count), 32'h0);
        check({tag, "_spd_10_100"}, 32'(speed_is_10_100), 32'h0);
        check({tag, "_spd_100"}, 32'(speed_is_100), 32'h0);
        check({tag, "_led"}, 32'(led_out), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   hi0, hi1, first_rise, second_rise;
        logic prev;
        logic found;

        rst           = 1'b1;
        status_vector = '0;
        led_sel_ch    = 3'd0;
        led_sel_hi    = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");

        // Both channels go good together; ch1 advertises 100 Mb/s.
        rst           = 1'b0;
        status_vector = {16'h0403, 16'h0803};
        repeat (16) tick();
        check("qual_not_yet_up", 32'(link_up), 32'h0);
        tick();
        check("link_up_both", 32'(link_up), 32'h3);
        check("link_change_both", 32'(link_change), 32'h3);
        tick();
        check("link_change_pulse_end", 32'(link_change), 32'h0);
        check("spd_10_100_up", 32'(speed_is_10_100), 32'h2);
        check("spd_100_up", 32'(speed_is_100), 32'h2);

        // Drop ch0 while UP.
        status_vector[15:0] = 16'h0801;
        tick();
        check("drop_link_up", 32'(link_up), 32'h2);
        check("drop_link_change", 32'(link_change), 32'h1);
        check("drop_flap0", 32'(flap_count[7:0]), 32'd1);
        check("drop_flap1", 32'(flap_count[15:8]), 32'd0);
        tick();
        check("drop_change_end", 32'(link_change), 32'h0);

        // Short good burst must not bring the link up; qualification restarts.
        status_vector[15:0] = 16'h0803;
        repeat (10) tick();
        status_vector[15:0] = 16'h0801;
        tick();
        check("short_burst_down", 32'(link_up[0]), 32'h0);
        status_vector[15:0] = 16'h0803;
        repeat (16) tick();
        check("requal_not_yet", 32'(link_up[0]), 32'h0);
        tick();
        check("requal_up", 32'(link_up[0]), 32'h1);
        check("requal_change", 32'(link_change[0]), 32'h1);
        check("qual_drop_no_flap", 32'(flap_count[7:0]), 32'd1);

        // ch1 speed: 11 holds, 00 selects 10 Mb/s.
        status_vector[31:16] = 16'h0C03;
        repeat (2) tick();
        check("spd_keep_10_100", 32'(speed_is_10_100[1]), 32'h1);
        check("spd_keep_100", 32'(speed_is_100[1]), 32'h1);
        status_vector[31:16] = 16'h0003;
        repeat (2) tick();
        check("spd_10_10_100", 32'(speed_is_10_100[1]), 32'h1);
        check("spd_10_100", 32'(speed_is_100[1]), 32'h0);

        // LED mux.
        status_vector[31:16] = 16'hA5C3;
        led_sel_ch = 3'd1;
        led_sel_hi = 1'b1;
        tick();
        check("led_ch1_hi", 32'(led_out), 32'hA5);
        led_sel_hi = 1'b0;
        tick();
        check("led_ch1_lo", 32'(led_out), 32'hC3);
        led_sel_ch = 3'd5;
        tick();
        check("led_out_of_range", 32'(led_out), 32'h00);
        led_sel_ch = 3'd0;
        led_sel_hi = 1'b1;
        tick();
        check("led_ch0_hi", 32'(led_out), 32'h08);

        // 300 flaps on ch0; count saturates at 255.
        for (int i = 0; i < 300; i++) begin
            status_vector[15:0] = 16'h0801;
            tick();
            if (i == 252) check("flap_254", 32'(flap_count[7:0]), 32'd254);
            status_vector[15:0] = 16'h0803;
            repeat (17) tick();
        end
        check("flap_loop_up", 32'(link_up[0]), 32'h1);
        check("flap_saturated", 32'(flap_count[7:0]), 32'd255);

        // Hold ch0 at zero status and watch for restart pulses.
        status_vector[15:0] = 16'h0000;
        tick();
        check("flap_stays_255", 32'(flap_count[7:0]), 32'd255);
        check("timeout_drop_change", 32'(link_change[0]), 32'h1);
        hi0 = 0; hi1 = 0; first_rise = -1; second_rise = -1;
        prev = an_restart[0];
        for (int i = 1; i <= 140; i++) begin
            tick();
            if (an_restart[1]) hi1++;
            if (an_restart[0]) begin
                hi0++;
                if (!prev) begin
                    if (first_rise < 0) first_rise = i;
                    else if (second_rise < 0) second_rise = i;
                end
            end
            prev = an_restart[0];
        end
        check("restart_ch1_quiet", 32'(hi1), 32'd0);
`ifdef LINK_MON_AUTO_RESTART_EN
        check("restart_first_rise", 32'(first_rise), 32'd64);
        check("restart_second_rise", 32'(second_rise), 32'd132);
        check("restart_high_cycles", 32'(hi0), 32'd8);

        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (an_restart[0]) found = 1'b1;
        end
        check("restart_seen", 32'(found), 32'h1);
        tick();
        check("restart_mid", 32'(an_restart[0]), 32'h1);
`else
        found = 1'b0;
        check("restart_never", 32'(hi0), 32'd0);
        check("down_waits", 32'(link_up[0]), 32'h0);
`endif

        // Reset with ch1 showing nonzero LED byte and 100 Mb/s speed.
        led_sel_ch = 3'd1;
        led_sel_hi = 1'b1;
        rst        = 1'b1;
        tick();
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        hi0 = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (an_restart[0]) hi0++;
        end
        check("no_partial_restart", 32'(hi0), 32'd0);
        check("post_reset_flap", 32'(flap_count[7:0]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
